// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Purpose : Shared types and default sizing for the 2R1W register file.
//           rf_state_t encodes the sweep-clear controller.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int C_DEF_DW    = 8;
    localparam int C_DEF_DEPTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module  : regfile_rd_port
// Purpose : One registered read port: entry mux, write-first bypass and
//           output register, for a DEPTH x DW register file.
// Ports   : clk, clr (async, active-high)
//           rsel          read address
//           mem, valid    flattened storage and per-entry valid bits
//           wr_acc, wsel, d   write accepted this edge, its address and data
//           q, v          registered read data and valid bit
// Revision: 1.0 - initial release
// ============================================================================
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DW      = C_DEF_DW,
    parameter int DEPTH   = C_DEF_DEPTH,
    parameter int AW      = $clog2(DEPTH),
    parameter int ZERO_R0 = 0
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [AW-1:0]              rsel,
    input  logic [DEPTH-1:0][DW-1:0]   mem,
    input  logic [DEPTH-1:0]           valid,
    input  logic                       wr_acc,
    input  logic [AW-1:0]              wsel,
    input  logic [DW-1:0]              d,
    output logic [DW-1:0]              q,
    output logic                       v
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [DW-1:0] w_q;
    logic          w_v;

    // Priority: out-of-range address, hard-zero entry, bypass, storage.
    always_comb begin
        w_q = '0;
        w_v = 1'b0;
        if ({1'b0, rsel} >= C_DEPTH) begin
            w_q = '0;
            w_v = 1'b0;
        end else if ((ZERO_R0 != 0) && (rsel == '0)) begin
            w_q = '0;
            w_v = 1'b1;
        end else if (wr_acc && (wsel == rsel)) begin
            w_q = d;
            w_v = 1'b1;
        end else begin
            w_q = mem[rsel];
            w_v = valid[rsel];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
            v <= 1'b0;
        end else begin
            q <= w_q;
            v <= w_v;
        end
    end

endmodule : regfile_rd_port
`default_nettype wire

// File: rtl/regfile_2r1w_param.sv
`default_nettype none
// ============================================================================
// Module  : regfile_2r1w_param
// Purpose : Parametrised 2-read/1-write register file with per-entry valid
//           bits, optional hard-zero entry 0 and a sequenced sweep-clear.
// Ports   : clk            rising-edge clock
//           clr            asynchronous active-high reset
//           en, wsel, d    write enable, address, data
//           rsel0, rsel1   read addresses
//           init           start sweep-clear (sampled at clk edge)
//           q0, q1, v0, v1 registered read data / valid bits
//           busy           sweep-clear in progress
// Revision: 1.0 - initial release
// ============================================================================
module regfile_2r1w_param
    import regfile_pkg::*;
#(
    parameter int DW      = C_DEF_DW,
    parameter int DEPTH   = C_DEF_DEPTH,
    parameter int AW      = $clog2(DEPTH),
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    input  logic [AW-1:0] wsel,
    input  logic [DW-1:0] d,
    input  logic [AW-1:0] rsel0,
    input  logic [AW-1:0] rsel1,
    input  logic          init,
    output logic [DW-1:0] q0,
    output logic [DW-1:0] q1,
    output logic          v0,
    output logic          v1,
    output logic          busy
);

    localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] C_LAST  = AW'(DEPTH - 1);

    rf_state_t                r_state;
    rf_state_t                w_state_nxt;
    logic [AW-1:0]            r_ptr;
    logic [AW-1:0]            w_ptr_nxt;
    logic [DEPTH-1:0][DW-1:0] r_mem;
    logic [DEPTH-1:0]         r_valid;
    logic                     w_busy;
    logic                     w_clear;
    logic                     w_wr_acc;

    // Write acceptance: never during a sweep, never out of range, and
    // never to a hard-wired zero entry.
    always_comb begin
        w_wr_acc = en && !w_busy && ({1'b0, wsel} < C_DEPTH)
                   && !((ZERO_R0 != 0) && (wsel == '0));
    end

    // Sweep controller: next state, pointer and outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_busy      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (init) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                w_busy  = 1'b1;
                w_clear = 1'b1;
                if (r_ptr == C_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt   = r_ptr + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Storage: sweep clear and writes are mutually exclusive because
    // writes are refused while the sweep runs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_mem   <= '0;
            r_valid <= '0;
        end else if (w_clear) begin
            r_mem[r_ptr]   <= '0;
            r_valid[r_ptr] <= 1'b0;
        end else if (w_wr_acc) begin
            r_mem[wsel]    <= d;
            r_valid[wsel]  <= 1'b1;
        end
    end

    assign busy = w_busy;

    regfile_rd_port #(
        .DW      (DW),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_rd0 (
        .clk    (clk),
        .clr    (clr),
        .rsel   (rsel0),
        .mem    (r_mem),
        .valid  (r_valid),
        .wr_acc (w_wr_acc),
        .wsel   (wsel),
        .d      (d),
        .q      (q0),
        .v      (v0)
    );

    regfile_rd_port #(
        .DW      (DW),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_rd1 (
        .clk    (clk),
        .clr    (clr),
        .rsel   (rsel1),
        .mem    (r_mem),
        .valid  (r_valid),
        .wr_acc (w_wr_acc),
        .wsel   (wsel),
        .d      (d),
        .q      (q1),
        .v      (v1)
    );

endmodule : regfile_2r1w_param
`default_nettype wire

// File: tb/tb_regfile_2r1w_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_2r1w_param
// Purpose : Self-checking bench for regfile_2r1w_param. One default instance
//           (DW=8, DEPTH=8) and one hard-zero instance (ZERO_R0=1, DEPTH=6).
//           Expected read results are queued when stimulus is driven and
//           popped after the sampling edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_2r1w_param;

    logic       clk = 1'b0;
    logic       clr;
    // default instance
    logic       en, init;
    logic [2:0] wsel, rsel0, rsel1;
    logic [7:0] d, q0, q1;
    logic       v0, v1, busy;
    // ZERO_R0 instance
    logic       en_z, init_z;
    logic [2:0] wsel_z, rsel0_z, rsel1_z;
    logic [7:0] d_z, q0_z, q1_z;
    logic       v0_z, v1_z, busy_z;

    typedef struct packed {
        logic [7:0] q0;
        logic       v0;
        logic [7:0] q1;
        logic       v1;
    } exp_t;

    exp_t sbq[$];
    exp_t sbq_z[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   busy_cnt;

    always #5 clk = ~clk;

    regfile_2r1w_param dut (
        .clk(clk), .clr(clr), .en(en), .wsel(wsel), .d(d),
        .rsel0(rsel0), .rsel1(rsel1), .init(init),
        .q0(q0), .q1(q1), .v0(v0), .v1(v1), .busy(busy)
    );

    regfile_2r1w_param #(.DW(8), .DEPTH(6), .ZERO_R0(1)) dut_z (
        .clk(clk), .clr(clr), .en(en_z), .wsel(wsel_z), .d(d_z),
        .rsel0(rsel0_z), .rsel1(rsel1_z), .init(init_z),
        .q0(q0_z), .q1(q1_z), .v0(v0_z), .v1(v1_z), .busy(busy_z)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({q0, v0, q1, v1, busy, q0_z, v0_z, q1_z, v1_z, busy_z} !== '0) begin
            bad++;
            $display("FAIL reset_state: got q0=%h v0=%b q1=%h v1=%b busy=%b zq0=%h zv0=%b zq1=%h zv1=%b zbusy=%b want all 0",
                     q0, v0, q1, v1, busy, q0_z, v0_z, q1_z, v1_z, busy_z);
        end
        @(negedge clk);
        clr = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rsel0 = 3'(a);
            rsel1 = 3'(7 - a);
            sbq.push_back(exp_t'({8'h00, 1'b0, 8'h00, 1'b0}));
            tick();
            e = sbq.pop_front();
            total++;
            if ({q0, v0, q1, v1} !== e) begin
                bad++;
                $display("FAIL rd_after_reset[%0d]: got %h/%b %h/%b want %h/%b %h/%b",
                         a, q0, v0, q1, v1, e.q0, e.v0, e.q1, e.v1);
            end
        end
    endtask

    task automatic test_write_read;
        en = 1'b1; wsel = 3'd3; d = 8'hA5;
        tick();
        wsel = 3'd7; d = 8'h3C;
        tick();
        en = 1'b0; rsel0 = 3'd3; rsel1 = 3'd7;
        sbq.push_back(exp_t'({8'hA5, 1'b1, 8'h3C, 1'b1}));
        tick();
        e = sbq.pop_front();
        total++;
        if ({q0, v0, q1, v1} !== e) begin
            bad++;
            $display("FAIL write_read: got %h/%b %h/%b want %h/%b %h/%b",
                     q0, v0, q1, v1, e.q0, e.v0, e.q1, e.v1);
        end
    endtask

    task automatic test_bypass;
        en = 1'b1; wsel = 3'd2; d = 8'h5A; rsel0 = 3'd2; rsel1 = 3'd3;
        sbq.push_back(exp_t'({8'h5A, 1'b1, 8'hA5, 1'b1}));
        tick();
        e = sbq.pop_front();
        total++;
        if ({q0, v0, q1, v1} !== e) begin
            bad++;
            $display("FAIL bypass: got %h/%b %h/%b want %h/%b %h/%b",
                     q0, v0, q1, v1, e.q0, e.v0, e.q1, e.v1);
        end
        en = 1'b0; rsel0 = 3'd7; rsel1 = 3'd7;
        sbq.push_back(exp_t'({8'h3C, 1'b1, 8'h3C, 1'b1}));
        tick();
        e = sbq.pop_front();
        total++;
        if ({q0, v0, q1, v1} !== e) begin
            bad++;
            $display("FAIL same_addr: got %h/%b %h/%b want %h/%b %h/%b",
                     q0, v0, q1, v1, e.q0, e.v0, e.q1, e.v1);
        end
    endtask

    task automatic test_sweep;
        for (int i = 0; i < 8; i++) begin
            en = 1'b1; wsel = 3'(i); d = 8'h10 + 8'(i);
            tick();
        end
        en = 1'b0; rsel0 = 3'd0; rsel1 = 3'd5;
        sbq.push_back(exp_t'({8'h10, 1'b1, 8'h15, 1'b1}));
        tick();
        e = sbq.pop_front();
        total++;
        if ({q0, v0, q1, v1} !== e) begin
            bad++;
            $display("FAIL fill_read: got %h/%b %h/%b want %h/%b %h/%b",
                     q0, v0, q1, v1, e.q0, e.v0, e.q1, e.v1);
        end
        // init edge also carries a write that must land
        init = 1'b1; en = 1'b1; wsel = 3'd6; d = 8'h77;
        tick();
        busy_cnt = busy ? 1 : 0;
        wsel = 3'd1; d = 8'hEE; rsel0 = 3'd6; rsel1 = 3'd0;
        sbq.push_back(exp_t'({8'h77, 1'b1, 8'h10, 1'b1}));
        for (int k = 1; k <= 8; k++) begin
            init = (k < 7) ? 1'b1 : 1'b0;
            tick();
            busy_cnt += busy ? 1 : 0;
            if (k == 1) begin
                e = sbq.pop_front();
                total++;
                if ({q0, v0, q1, v1} !== e) begin
                    bad++;
                    $display("FAIL sweep_preclear: got %h/%b %h/%b want %h/%b %h/%b",
                             q0, v0, q1, v1, e.q0, e.v0, e.q1, e.v1);
                end
            end
        end
        en = 1'b0; init = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_end: got %b want 0", busy);
        end
        tick();
        busy_cnt += busy ? 1 : 0;
        total++;
        if (busy_cnt != 8) begin
            bad++;
            $display("FAIL busy_cycles: got %0d want 8", busy_cnt);
        end
        for (int a = 0; a < 8; a++) begin
            rsel0 = 3'(a);
            rsel1 = 3'(7 - a);
            sbq.push_back(exp_t'({8'h00, 1'b0, 8'h00, 1'b0}));
            tick();
            e = sbq.pop_front();
            total++;
            if ({q0, v0, q1, v1} !== e) begin
                bad++;
                $display("FAIL rd_after_sweep[%0d]: got %h/%b %h/%b want %h/%b %h/%b",
                         a, q0, v0, q1, v1, e.q0, e.v0, e.q1, e.v1);
            end
        end
    endtask

    task automatic test_clr_abort;
        en = 1'b1; wsel = 3'd4; d = 8'h44;
        tick();
        en = 1'b0; init = 1'b1;
        tick();
        init = 1'b0; rsel0 = 3'd4; rsel1 = 3'd4;
        tick();
        sbq.push_back(exp_t'({8'h44, 1'b1, 8'h44, 1'b1}));
        tick();
        e = sbq.pop_front();
        total++;
        if ({q0, v0, q1, v1} !== e) begin
            bad++;
            $display("FAIL sweep_read: got %h/%b %h/%b want %h/%b %h/%b",
                     q0, v0, q1, v1, e.q0, e.v0, e.q1, e.v1);
        end
        clr = 1'b1;
        #1;
        total++;
        if ({busy, q0, v0, q1, v1} !== '0) begin
            bad++;
            $display("FAIL clr_abort: got busy=%b q0=%h v0=%b q1=%h v1=%b want all 0",
                     busy, q0, v0, q1, v1);
        end
        #2;
        clr = 1'b0;
        en = 1'b1; wsel = 3'd5; d = 8'hC3;
        tick();
        en = 1'b0; rsel0 = 3'd5; rsel1 = 3'd4;
        sbq.push_back(exp_t'({8'hC3, 1'b1, 8'h00, 1'b0}));
        tick();
        e = sbq.pop_front();
        total++;
        if ({q0, v0, q1, v1} !== e) begin
            bad++;
            $display("FAIL write_after_abort: got %h/%b %h/%b want %h/%b %h/%b",
                     q0, v0, q1, v1, e.q0, e.v0, e.q1, e.v1);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_abort: got %b want 0", busy);
        end
    endtask

    task automatic test_zero_r0;
        // {wsel, d, en, rsel0, rsel1} per step, with expected read result
        logic [2:0] t_wsel [5] = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd0};
        logic [7:0] t_d    [5] = '{8'hFF, 8'hFF, 8'h5E, 8'h00, 8'h00};
        logic       t_en   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0] t_r0   [5] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7};
        logic [2:0] t_r1   [5] = '{3'd6, 3'd6, 3'd5, 3'd6, 3'd5};
        exp_t       t_exp  [5];
        t_exp[0] = exp_t'({8'h00, 1'b1, 8'h00, 1'b0});
        t_exp[1] = exp_t'({8'h00, 1'b1, 8'h00, 1'b0});
        t_exp[2] = exp_t'({8'h00, 1'b1, 8'h5E, 1'b1});
        t_exp[3] = exp_t'({8'h00, 1'b1, 8'h00, 1'b0});
        t_exp[4] = exp_t'({8'h00, 1'b0, 8'h5E, 1'b1});
        for (int s = 0; s < 5; s++) begin
            en_z = t_en[s]; wsel_z = t_wsel[s]; d_z = t_d[s];
            rsel0_z = t_r0[s]; rsel1_z = t_r1[s];
            sbq_z.push_back(t_exp[s]);
            tick();
            e = sbq_z.pop_front();
            total++;
            if ({q0_z, v0_z, q1_z, v1_z} !== e) begin
                bad++;
                $display("FAIL zero_r0[%0d]: got %h/%b %h/%b want %h/%b %h/%b",
                         s, q0_z, v0_z, q1_z, v1_z, e.q0, e.v0, e.q1, e.v1);
            end
        end
        en_z = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr = 1'b1;
        en = 1'b0; init = 1'b0; wsel = '0; d = '0; rsel0 = '0; rsel1 = '0;
        en_z = 1'b0; init_z = 1'b0; wsel_z = '0; d_z = '0; rsel0_z = '0; rsel1_z = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_sweep();
        test_clr_abort();
        test_zero_r0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_2r1w_param
`default_nettype wire
